// File: rtl/serial_adder_if.sv
// Request/result bundle of the digit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             carry_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;
    logic             zero_o;

    modport master (
        output start_i, sub_i, a_i, b_i, carry_i,
        input  busy_o, done_o, sum_o, carry_o, overflow_o, zero_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i, carry_i,
        output busy_o, done_o, sum_o, carry_o, overflow_o, zero_o
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB slice first,
// and publishes the whole result (sum, carry, overflow, zero) at once.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // operand A, shifted right one slice per cycle
    logic [WIDTH-1:0] r_b;      // operand B (already inverted for subtract)
    logic [WIDTH-1:0] r_acc;    // partial sum, filled from the MSB end
    logic             r_cy;     // carry between slices
    logic [CW-1:0]    r_cnt;    // slices already added
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT-1:0] w_slice;
    logic             w_cmsb;   // carry into the top bit of the current slice
    logic             w_cout;   // carry out of the current slice
    logic [WIDTH-1:0] w_slice_ext;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_accept;

    // Ripple-add the lowest DIGIT bits of the working operands
    always_comb begin
        logic c;
        c       = r_cy;
        w_slice = '0;
        w_cmsb  = r_cy;
        for (int i = 0; i < DIGIT; i++) begin
            w_cmsb     = c;
            w_slice[i] = r_a[i] ^ r_b[i] ^ c;
            c          = (r_a[i] & r_b[i]) | (c & (r_a[i] ^ r_b[i]));
        end
        w_cout = c;
    end

    // New slice enters at the top; after N slices the LSB slice sits at bit 0
    assign w_slice_ext = WIDTH'(w_slice);
    assign w_acc_nxt   = (r_acc >> DIGIT) | (w_slice_ext << (WIDTH - DIGIT));

    // Start is only honoured when no operation is in flight
    assign w_accept = bus.start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Control FSM plus datapath; results only change on the final slice
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        // Subtract is A + ~B + ~borrow; carry chain starts fresh
                        r_a     <= bus.a_i;
                        r_b     <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        r_cy    <= bus.carry_i ^ bus.sub_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_cy  <= w_cout;
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_sum   <= w_acc_nxt;
                        r_carry <= w_cout;
                        r_ovf   <= w_cmsb ^ w_cout;
                        r_zero  <= (w_acc_nxt == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.sum_o      = r_sum;
    assign bus.carry_o    = r_carry;
    assign bus.overflow_o = r_ovf;
    assign bus.zero_o     = r_zero;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: random and directed operations on an
// 8-bit/1-bit-digit instance, plus latency/result checks on 8/4 and 16/2.
module tb_serial_adder;
    typedef struct {
        logic [15:0] sum;
        bit          cy;
        bit          ovf;
        bit          zero;
        int          acc_edge;
        int          done_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   edge_cnt = 0;
    int   next_ok  = 1 << 30;
    int   last_acc = 0;
    int   vectors  = 0;
    int   miscompares = 0;
    int   sec_done = 0;
    exp_t q[$];

    logic [7:0] h_sum  = 8'h00;
    bit         h_cy   = 1'b0;
    bit         h_ovf  = 1'b0;
    bit         h_zero = 1'b1;

    serial_adder_if #(.WIDTH(8))  bus  ();
    serial_adder_if #(.WIDTH(8))  bus2 ();
    serial_adder_if #(.WIDTH(16)) bus3 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) dut  (.clk_i(clk), .rst_n_i(rst_n),  .bus(bus));
    serial_adder #(.WIDTH(8),  .DIGIT(4)) dut2 (.clk_i(clk), .rst_n_i(rst2_n), .bus(bus2));
    serial_adder #(.WIDTH(16), .DIGIT(2)) dut3 (.clk_i(clk), .rst_n_i(rst2_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit sub, input bit cin);
        exp_t r;
        longint unsigned m, full;
        longint sa, sb, sr, half, ci;
        m    = 64'd1 << w;
        half = longint'(m / 2);
        ci   = cin ? 1 : 0;
        full = sub ? (m + a - b - longint'(ci)) : (a + b + longint'(ci));
        r.sum  = 16'(full % m);
        r.cy   = ((full / m) % 2) != 0;
        r.zero = (full % m) == 0;
        sa = (longint'(a) >= half) ? longint'(a) - longint'(m) : longint'(a);
        sb = (longint'(b) >= half) ? longint'(b) - longint'(m) : longint'(b);
        sr = sub ? (sa - sb - ci) : (sa + sb + ci);
        r.ovf = (sr >= half) || (sr < -half);
        r.acc_edge  = 0;
        r.done_edge = 0;
        return r;
    endfunction

    // Drive one cycle of inputs; log an expectation if the next edge accepts
    task automatic step(input bit st, input logic [7:0] a, input logic [7:0] b,
                        input bit sub, input bit cin);
        exp_t e;
        bus.start_i = st;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.sub_i   = sub;
        bus.carry_i = cin;
        if (st && rst_n && (edge_cnt + 1 >= next_ok)) begin
            e = model(8, a, b, sub, cin);
            e.acc_edge  = edge_cnt + 1;
            e.done_edge = edge_cnt + 1 + 8;
            q.push_back(e);
            next_ok  = edge_cnt + 1 + 9;
            last_acc = e.acc_edge;
        end
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] sp [4];
        sp[0] = 8'h00; sp[1] = 8'hFF; sp[2] = 8'h7F; sp[3] = 8'h80;
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 8'($urandom);
    endfunction

    task automatic rnd_step(input bit st);
        step(st, pick(), pick(), 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_ok();
        while (edge_cnt + 1 < next_ok) rnd_step(1'($urandom));
    endtask

    // Monitor: busy/done timing and held results against the scoreboard
    always @(negedge clk) begin
        int   e_now;
        bit   bexp, dexp;
        exp_t e;
        e_now = edge_cnt;
        bexp = (q.size() > 0) && (q[0].acc_edge <= e_now) && (e_now < q[0].done_edge);
        dexp = (q.size() > 0) && (q[0].done_edge == e_now);
        chk("busy", bus.busy_o, bexp);
        chk("done", bus.done_o, dexp);
        if (dexp) begin
            e = q.pop_front();
            h_sum  = e.sum[7:0];
            h_cy   = e.cy;
            h_ovf  = e.ovf;
            h_zero = e.zero;
        end
        chk("sum",      bus.sum_o,      h_sum);
        chk("carry",    bus.carry_o,    h_cy);
        chk("overflow", bus.overflow_o, h_ovf);
        chk("zero",     bus.zero_o,     h_zero);
    end

    // Main stimulus on the 8-bit, 1-bit-digit instance
    initial begin
        int acc;
        int guard;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.sub_i = 1'b0; bus.carry_i = 1'b0;
        repeat (3) rnd_step(1'b1);
        rst_n   = 1'b1;
        next_ok = edge_cnt + 1;
        // first edge after release accepts
        step(1'b1, 8'h3C, 8'h05, 1'b0, 1'b0);
        repeat (10) rnd_step(1'b0);
        wait_ok(); step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_ok(); step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_ok(); step(1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
        wait_ok(); step(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
        wait_ok(); step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        wait_ok(); step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        wait_ok(); step(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        // start held high: one acceptance every N+1 edges
        repeat (200) rnd_step(1'b1);
        // random mix of idle gaps, ignored starts and back-to-back ops
        repeat (600) rnd_step(1'($urandom));
        // reset on the 4th RUN edge aborts the op with no done pulse
        wait_ok();
        step(1'b1, 8'h3C, 8'h05, 1'b0, 1'b0);
        acc = last_acc;
        while (edge_cnt < acc + 4) rnd_step(1'b0);
        rst_n = 1'b0;
        q.delete();
        h_sum = 8'h00; h_cy = 1'b0; h_ovf = 1'b0; h_zero = 1'b1;
        next_ok = 1 << 30;
        repeat (2) rnd_step(1'b1);
        rst_n   = 1'b1;
        next_ok = edge_cnt + 1;
        step(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        repeat (12) rnd_step(1'b0);
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            rnd_step(1'b0);
            guard++;
        end
        chk("queue_drained", q.size(), 0);
        guard = 0;
        while (sec_done == 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("wide_digit_blocks_done", sec_done, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Multi-bit digit instances: latency and result of single operations
    initial begin
        exp_t e;
        int   lat;
        logic [15:0] a, b;
        bit   s, c;
        rst2_n = 1'b0;
        bus2.start_i = 1'b0; bus2.a_i = '0; bus2.b_i = '0; bus2.sub_i = 1'b0; bus2.carry_i = 1'b0;
        bus3.start_i = 1'b0; bus3.a_i = '0; bus3.b_i = '0; bus3.sub_i = 1'b0; bus3.carry_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("d4_rst_zero", bus2.zero_o, 1'b1);
        chk("d4_rst_busy", bus2.busy_o, 1'b0);
        rst2_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 16'h00FF : 16'($urandom_range(0, 255));
            b = (t == 0) ? 16'h0001 : 16'($urandom_range(0, 255));
            s = (t == 0) ? 1'b0 : 1'($urandom);
            c = (t == 0) ? 1'b0 : 1'($urandom);
            e = model(8, a, b, s, c);
            bus2.a_i = a[7:0]; bus2.b_i = b[7:0]; bus2.sub_i = s; bus2.carry_i = c;
            bus2.start_i = 1'b1;
            @(posedge clk); #2;
            bus2.start_i = 1'b0;
            bus2.a_i = 8'($urandom); bus2.b_i = 8'($urandom);
            lat = 0;
            while (!bus2.done_o && lat < 20) begin
                @(posedge clk); #2;
                lat++;
            end
            chk("d4_latency", lat, 2);
            chk("d4_sum", bus2.sum_o, e.sum[7:0]);
            chk("d4_carry", bus2.carry_o, e.cy);
            chk("d4_overflow", bus2.overflow_o, e.ovf);
            chk("d4_zero", bus2.zero_o, e.zero);
            @(posedge clk); #2;
        end
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 16'h7FFF : 16'($urandom);
            b = (t == 0) ? 16'h0001 : 16'($urandom);
            s = (t == 0) ? 1'b0 : 1'($urandom);
            c = (t == 0) ? 1'b0 : 1'($urandom);
            e = model(16, a, b, s, c);
            bus3.a_i = a; bus3.b_i = b; bus3.sub_i = s; bus3.carry_i = c;
            bus3.start_i = 1'b1;
            @(posedge clk); #2;
            bus3.start_i = 1'b0;
            bus3.a_i = 16'($urandom); bus3.b_i = 16'($urandom);
            lat = 0;
            while (!bus3.done_o && lat < 40) begin
                @(posedge clk); #2;
                lat++;
            end
            chk("d16_latency", lat, 8);
            chk("d16_sum", bus3.sum_o, e.sum);
            chk("d16_carry", bus3.carry_o, e.cy);
            chk("d16_overflow", bus3.overflow_o, e.ovf);
            chk("d16_zero", bus3.zero_o, e.zero);
            @(posedge clk); #2;
        end
        sec_done = 1;
    end
endmodule
